pwm_phase_gen: RTL and testbench

//  Shared PWM timebase that feeds every pwm_chan instance in the PWM block.

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_prescaler.sv | 19 +
 rtl/pwm_phase_gen.sv | 68 ++++++
 tb/tb_pwm_phase_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM widths, phase-generator states and the phase-step helper.
package pwm_pkg;
  localparam int PhaseW = 16;
  localparam int ClkDivWDefault = 27;
  typedef enum logic {PhIdle, PhRun} pwm_ph_state_e;
  function automatic logic [PhaseW-1:0] pwm_phase_step(input logic [3:0] resn);
    return 16'h8000 >> resn;
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk_i into one beat every clk_div+1 enabled cycles.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int ClkDivW = ClkDivWDefault
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en,
  input  logic [ClkDivW-1:0] clk_div,
  output logic               beat
);
  logic [ClkDivW-1:0] cnt_q;
  assign beat = en && (cnt_q == clk_div);
  // A divider lowered below the live count just rolls over; no lock-up.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= (!en || beat) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/pwm_phase_gen.sv
// pwm_phase_gen: shared PWM timebase (phase counter, cycle-end and blink-clear pulses).
// PWM_CFG_SHADOW_EN: latch clk_div/dc_resn only in idle and at period wrap.
module pwm_phase_gen
  import pwm_pkg::*;
#(
  parameter int ClkDivW = ClkDivWDefault
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cntr_en_i,
  input  logic [ClkDivW-1:0] clk_div_i,
  input  logic [3:0]         dc_resn_i,
  input  logic               cfg_upd_i,
  output logic [PhaseW-1:0]  phase_ctr_o,
  output logic               cycle_end_o,
  output logic               clr_blink_cntr_o,
  output logic [3:0]         dc_resn_o
);
  pwm_ph_state_e state_q, state_d;
  logic run, start, beat;
  logic [ClkDivW-1:0] clk_div_eff;
  logic [3:0] dc_resn_eff;
  logic [PhaseW:0] sum;
  always_comb begin
    state_d = cntr_en_i ? PhRun : PhIdle;
    run = (state_q == PhRun) && cntr_en_i;
    start = (state_q == PhIdle) && cntr_en_i;
    sum = {1'b0, phase_ctr_o} + {1'b0, pwm_phase_step(dc_resn_eff)};
  end
  pwm_prescaler #(.ClkDivW(ClkDivW)) u_prescaler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en      (run),
    .clk_div (clk_div_eff),
    .beat    (beat)
  );
  // Leaving RUN clears the phase and swallows a wrap that would land on that edge.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q          <= PhIdle;
      phase_ctr_o      <= '0;
      cycle_end_o      <= 1'b0;
      clr_blink_cntr_o <= 1'b0;
    end else begin
      state_q          <= state_d;
      phase_ctr_o      <= !run ? '0 : beat ? sum[PhaseW-1:0] : phase_ctr_o;
      cycle_end_o      <= beat && sum[PhaseW];
      clr_blink_cntr_o <= cfg_upd_i || start;
    end
`ifdef PWM_CFG_SHADOW_EN
  logic [ClkDivW-1:0] clk_div_q;
  logic [3:0] dc_resn_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      clk_div_q <= '0;
      dc_resn_q <= '0;
    end else if (state_q == PhIdle || (beat && sum[PhaseW])) begin
      clk_div_q <= clk_div_i;
      dc_resn_q <= dc_resn_i;
    end
  assign clk_div_eff = clk_div_q;
  assign dc_resn_eff = dc_resn_q;
`else
  assign clk_div_eff = clk_div_i;
  assign dc_resn_eff = dc_resn_i;
`endif
  assign dc_resn_o = dc_resn_eff;
endmodule

// File: tb/tb_pwm_phase_gen.sv
// tb_pwm_phase_gen: directed self-checking bench for pwm_phase_gen.
module tb_pwm_phase_gen;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cntr_en_i = 1'b0;
  logic [26:0] clk_div_i = '0;
  logic [3:0]  dc_resn_i = '0;
  logic        cfg_upd_i = 1'b0;
  logic [15:0] phase_ctr_o;
  logic        cycle_end_o;
  logic        clr_blink_cntr_o;
  logic [3:0]  dc_resn_o;
  int n_cmp = 0;
  int n_bad = 0;

  pwm_phase_gen dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .cntr_en_i        (cntr_en_i),
    .clk_div_i        (clk_div_i),
    .dc_resn_i        (dc_resn_i),
    .cfg_upd_i        (cfg_upd_i),
    .phase_ctr_o      (phase_ctr_o),
    .cycle_end_o      (cycle_end_o),
    .clr_blink_cntr_o (clr_blink_cntr_o),
    .dc_resn_o        (dc_resn_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic go_idle();
    cntr_en_i = 1'b0;
    cfg_upd_i = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    dc_resn_i = 4'd0;
    #3;
    n_cmp++;
    if ({phase_ctr_o, cycle_end_o, clr_blink_cntr_o, dc_resn_o} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset: phase=%h ce=%b clr=%b resn=%h required all 0", phase_ctr_o, cycle_end_o, clr_blink_cntr_o, dc_resn_o);
    end
    tick(2);
    rst_ni = 1'b1;
    tick(2);
    n_cmp++;
    if (phase_ctr_o !== 16'h0 || clr_blink_cntr_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: phase=%h clr=%b required 0/0", phase_ctr_o, clr_blink_cntr_o);
    end
  endtask

  task automatic test_div2_resn3();
    int k;
    logic [15:0] exp_ph;
    logic exp_ce;
    clk_div_i = 27'd2;
    dc_resn_i = 4'd3;
    cntr_en_i = 1'b1;
    tick();
    n_cmp++;
    if (clr_blink_cntr_o !== 1'b1) begin
      n_bad++;
      $display("FAIL start_clr: clr=%b required 1", clr_blink_cntr_o);
    end
    for (int i = 2; i <= 100; i++) begin
      tick();
      k = (i - 1) / 3;
      exp_ph = 16'((k % 16) * 16'h1000);
      exp_ce = (i > 1) && ((i - 1) % 48 == 0);
      n_cmp++;
      if (phase_ctr_o !== exp_ph || cycle_end_o !== exp_ce || clr_blink_cntr_o !== 1'b0) begin
        n_bad++;
        $display("FAIL div2_cyc%0d: phase=%h ce=%b clr=%b required %h/%b/0", i, phase_ctr_o, cycle_end_o, clr_blink_cntr_o, exp_ph, exp_ce);
      end
    end
    go_idle();
  endtask

  task automatic test_div0_resn0();
    logic [15:0] exp_ph;
    logic exp_ce;
    clk_div_i = 27'd0;
    dc_resn_i = 4'd0;
    cntr_en_i = 1'b1;
    tick();
    n_cmp++;
    if (phase_ctr_o !== 16'h0 || cycle_end_o !== 1'b0) begin
      n_bad++;
      $display("FAIL div0_first: phase=%h ce=%b required 0000/0", phase_ctr_o, cycle_end_o);
    end
    for (int i = 2; i <= 12; i++) begin
      tick();
      exp_ph = (i % 2 == 0) ? 16'h8000 : 16'h0000;
      exp_ce = (i >= 3) && (i % 2 == 1);
      n_cmp++;
      if (phase_ctr_o !== exp_ph || cycle_end_o !== exp_ce) begin
        n_bad++;
        $display("FAIL div0_cyc%0d: phase=%h ce=%b required %h/%b", i, phase_ctr_o, cycle_end_o, exp_ph, exp_ce);
      end
    end
    go_idle();
  endtask

  task automatic test_disable();
    clk_div_i = 27'd0;
    dc_resn_i = 4'd3;
    cntr_en_i = 1'b1;
    tick(6);
    n_cmp++;
    if (phase_ctr_o !== 16'h5000) begin
      n_bad++;
      $display("FAIL dis_setup: phase=%h required 5000", phase_ctr_o);
    end
    cntr_en_i = 1'b0;
    tick();
    n_cmp++;
    if (phase_ctr_o !== 16'h0 || cycle_end_o !== 1'b0 || clr_blink_cntr_o !== 1'b0) begin
      n_bad++;
      $display("FAIL dis_clear: phase=%h ce=%b clr=%b required 0/0/0", phase_ctr_o, cycle_end_o, clr_blink_cntr_o);
    end
    tick(2);
    cntr_en_i = 1'b1;
    tick();
    n_cmp++;
    if (clr_blink_cntr_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reen_clr: clr=%b required 1", clr_blink_cntr_o);
    end
    tick();
    n_cmp++;
    if (clr_blink_cntr_o !== 1'b0 || phase_ctr_o !== 16'h1000) begin
      n_bad++;
      $display("FAIL reen_next: clr=%b phase=%h required 0/1000", clr_blink_cntr_o, phase_ctr_o);
    end
    tick(14);
    n_cmp++;
    if (phase_ctr_o !== 16'hF000) begin
      n_bad++;
      $display("FAIL wrap_setup: phase=%h required f000", phase_ctr_o);
    end
    cntr_en_i = 1'b0;
    tick();
    n_cmp++;
    if (phase_ctr_o !== 16'h0 || cycle_end_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_suppress: phase=%h ce=%b required 0/0", phase_ctr_o, cycle_end_o);
    end
    tick();
    n_cmp++;
    if (cycle_end_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_ce: ce=%b required 0", cycle_end_o);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int pulses;
    cntr_en_i = 1'b1;
    cfg_upd_i = 1'b1;
    tick();
    cfg_upd_i = 1'b0;
    pulses = clr_blink_cntr_o ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulses += clr_blink_cntr_o ? 1 : 0;
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL coincident_clr: pulses=%0d required 1", pulses);
    end
    cfg_upd_i = 1'b1;
    tick();
    cfg_upd_i = 1'b0;
    n_cmp++;
    if (clr_blink_cntr_o !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_upd_clr: clr=%b required 1", clr_blink_cntr_o);
    end
    tick();
    n_cmp++;
    if (clr_blink_cntr_o !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_upd_end: clr=%b required 0", clr_blink_cntr_o);
    end
    go_idle();
  endtask

  task automatic test_resn_change();
    clk_div_i = 27'd0;
    dc_resn_i = 4'd3;
    cntr_en_i = 1'b1;
    tick(5);
    n_cmp++;
    if (phase_ctr_o !== 16'h4000) begin
      n_bad++;
      $display("FAIL resn_setup: phase=%h required 4000", phase_ctr_o);
    end
    dc_resn_i = 4'd4;
`ifdef PWM_CFG_SHADOW_EN
    tick();
    n_cmp++;
    if (phase_ctr_o !== 16'h5000 || dc_resn_o !== 4'd3) begin
      n_bad++;
      $display("FAIL shadow_hold: phase=%h resn=%h required 5000/3", phase_ctr_o, dc_resn_o);
    end
    tick(10);
    n_cmp++;
    if (phase_ctr_o !== 16'hF000 || dc_resn_o !== 4'd3) begin
      n_bad++;
      $display("FAIL shadow_prewrap: phase=%h resn=%h required f000/3", phase_ctr_o, dc_resn_o);
    end
    tick();
    n_cmp++;
    if (phase_ctr_o !== 16'h0 || cycle_end_o !== 1'b1 || dc_resn_o !== 4'd4) begin
      n_bad++;
      $display("FAIL shadow_wrap: phase=%h ce=%b resn=%h required 0000/1/4", phase_ctr_o, cycle_end_o, dc_resn_o);
    end
    tick();
    n_cmp++;
    if (phase_ctr_o !== 16'h0800) begin
      n_bad++;
      $display("FAIL shadow_newstep: phase=%h required 0800", phase_ctr_o);
    end
`else
    #1;
    n_cmp++;
    if (dc_resn_o !== 4'd4) begin
      n_bad++;
      $display("FAIL live_resn: resn=%h required 4", dc_resn_o);
    end
    tick();
    n_cmp++;
    if (phase_ctr_o !== 16'h4800) begin
      n_bad++;
      $display("FAIL live_step1: phase=%h required 4800", phase_ctr_o);
    end
    tick();
    n_cmp++;
    if (phase_ctr_o !== 16'h5000) begin
      n_bad++;
      $display("FAIL live_step2: phase=%h required 5000", phase_ctr_o);
    end
`endif
    go_idle();
  endtask

  task automatic test_async_reset();
    clk_div_i = 27'd0;
    dc_resn_i = 4'd3;
    cntr_en_i = 1'b1;
    tick(11);
    n_cmp++;
    if (phase_ctr_o !== 16'hA000) begin
      n_bad++;
      $display("FAIL arst_setup: phase=%h required a000", phase_ctr_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (phase_ctr_o !== 16'h0 || cycle_end_o !== 1'b0 || clr_blink_cntr_o !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_now: phase=%h ce=%b clr=%b required 0/0/0", phase_ctr_o, cycle_end_o, clr_blink_cntr_o);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    n_cmp++;
    if (clr_blink_cntr_o !== 1'b1 || phase_ctr_o !== 16'h0) begin
      n_bad++;
      $display("FAIL arst_idle: clr=%b phase=%h required 1/0000", clr_blink_cntr_o, phase_ctr_o);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_div2_resn3();
    test_div0_resn0();
    test_disable();
    test_back_to_back();
    test_resn_change();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
